// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte signals of the UART receiver
interface uart_rx_if;
   logic              rx_i;
   logic signed [7:0] data_o;
   logic              valid_o;
   logic              frame_err_o;
   logic              parity_err_o;

   modport slave (
      input  rx_i,
      output data_o,
      output valid_o,
      output frame_err_o,
      output parity_err_o
   );

   modport master (
      output rx_i,
      input  data_o,
      input  valid_o,
      input  frame_err_o,
      input  parity_err_o
   );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-bit UART receiver, mid-bit sampling; `UART_RX_PARITY_EN adds an even-parity bit
module uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input logic      clk,
   input logic      rst,
   uart_rx_if.slave bus
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] FULL_TICK = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_TICK = TW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_HIGH
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      sync_q;
   logic            rx_s;
   logic [TW-1:0]   timer_q, timer_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            tick;
   logic            stop_tick;
`ifdef UART_RX_PARITY_EN
   logic            par_err_q, par_err_d;
   logic            perr_q, perr_d;
`endif

   assign rx_s = sync_q[1];

   always_comb begin
      tick = 1'b0;
      case (state_q)
         S_START:  tick = (timer_q == HALF_TICK);
         S_DATA,
`ifdef UART_RX_PARITY_EN
         S_PARITY,
`endif
         S_STOP:   tick = (timer_q == FULL_TICK);
         default:  tick = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sync_q    <= 2'b11;
         timer_q   <= '0;
         idx_q     <= 3'd0;
         shift_q   <= 8'd0;
`ifdef UART_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[0], bus.rx_i};
         timer_q   <= timer_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
         par_err_q <= par_err_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
      par_err_d = par_err_q;
`endif
      case (state_q)
         S_IDLE: begin
`ifdef UART_RX_PARITY_EN
            par_err_d = 1'b0;
`endif
            if (!rx_s) state_d = S_START;
         end
         // A start bit that is high again at mid-bit is a glitch, not a frame.
         S_START: if (tick) state_d = rx_s ? S_IDLE : S_DATA;
         S_DATA: if (tick) begin
            shift_d = {rx_s, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (idx_q == 3'd7) state_d = S_PARITY;
`else
            if (idx_q == 3'd7) state_d = S_STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: if (tick) begin
            par_err_d = rx_s ^ (^shift_q);
            state_d   = S_STOP;
         end
`endif
         S_STOP: if (tick) state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
         S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (tick || (state_d != state_q) || (state_q == S_IDLE) || (state_q == S_WAIT_HIGH))
         timer_d = '0;
      else
         timer_d = timer_q + TW'(1);
   end

   always_comb begin
      stop_tick = (state_q == S_STOP) && tick;
`ifdef UART_RX_PARITY_EN
      valid_d   = stop_tick && rx_s && !par_err_q;
      perr_d    = stop_tick && rx_s && par_err_q;
`else
      valid_d   = stop_tick && rx_s;
`endif
      ferr_d    = stop_tick && !rx_s;
      data_d    = valid_d ? shift_q : data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= 8'd0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign bus.data_o      = $signed(data_q);
   assign bus.valid_o     = valid_q;
   assign bus.frame_err_o = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err_o = perr_q;
`else
   assign bus.parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx at CLKS_PER_BIT=16
module tb_uart_rx;
   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME   = 11 * CPB;
   localparam int LATENCY = 171;
`else
   localparam int FRAME   = 10 * CPB;
   localparam int LATENCY = 155;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   uart_rx_if bus ();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         last_start;
   int         n_ferr, n_perr, n_multi;
   logic [7:0] q_data[$];
   int         q_vcyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.valid_o === 1'b1) begin
         q_data.push_back(bus.data_o);
         q_vcyc.push_back(cyc);
      end
      if (bus.frame_err_o === 1'b1) n_ferr++;
      if (bus.parity_err_o === 1'b1) n_perr++;
      if ((32'(bus.valid_o) + 32'(bus.frame_err_o) + 32'(bus.parity_err_o)) > 1) n_multi++;
   end

   task automatic clear_mon();
      q_data.delete();
      q_vcyc.delete();
      n_ferr = 0;
      n_perr = 0;
   endtask

   task automatic drive_bit(input logic b, input int cycles);
      bus.rx_i = b;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      last_start = cyc;
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
      drive_bit(^d, CPB);
`endif
      drive_bit(stop, CPB);
   endtask

   task automatic check_one_valid(input string name, input logic [7:0] exp);
      n_checks++;
      if (q_data.size() !== 1) begin
         n_fail++;
         $display("FAIL %s_count: got %0d valid pulses, expected 1", name, q_data.size());
      end else begin
         n_checks++;
         if (q_data[0] !== exp) begin
            n_fail++;
            $display("FAIL %s_data: got %02h, expected %02h", name, q_data[0], exp);
         end
      end
   endtask

   task automatic test_reset();
      bus.rx_i = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks += 4;
      if (bus.data_o !== 8'sd0) begin n_fail++; $display("FAIL reset_data: got %02h, expected 00", bus.data_o); end
      if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", bus.valid_o); end
      if (bus.frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b, expected 0", bus.frame_err_o); end
      if (bus.parity_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b, expected 0", bus.parity_err_o); end
      rst = 1'b0;
      drive_bit(1'b1, 2 * CPB);
   endtask

   task automatic test_single();
      clear_mon();
      send_frame(8'hA5, 1'b1);
      drive_bit(1'b1, 2 * CPB);
      check_one_valid("single", 8'hA5);
      n_checks += 4;
      if (bus.data_o !== -8'sd91) begin n_fail++; $display("FAIL single_signed: got %0d, expected -91", bus.data_o); end
      if (q_vcyc.size() > 0 && (q_vcyc[0] - last_start) !== LATENCY) begin
         n_fail++;
         $display("FAIL single_latency: got %0d cycles, expected %0d", q_vcyc[0] - last_start, LATENCY);
      end
      if (n_ferr !== 0) begin n_fail++; $display("FAIL single_ferr: got %0d pulses, expected 0", n_ferr); end
      if (n_perr !== 0) begin n_fail++; $display("FAIL single_perr: got %0d pulses, expected 0", n_perr); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
      logic [31:0] merged;
      clear_mon();
      for (int i = 0; i < 4; i++) send_frame(bytes[i], 1'b1);
      drive_bit(1'b1, 2 * CPB);
      n_checks++;
      if (q_data.size() !== 4) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d valid pulses, expected 4", q_data.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (q_data[i] !== bytes[i]) begin
               n_fail++;
               $display("FAIL b2b_data%0d: got %02h, expected %02h", i, q_data[i], bytes[i]);
            end
         end
         for (int i = 1; i < 4; i++) begin
            n_checks++;
            if ((q_vcyc[i] - q_vcyc[i-1]) !== FRAME) begin
               n_fail++;
               $display("FAIL b2b_spacing%0d: got %0d, expected %0d", i, q_vcyc[i] - q_vcyc[i-1], FRAME);
            end
         end
         merged = {q_data[0], q_data[1], q_data[2], q_data[3]};
         n_checks++;
         if (merged !== 32'h12345678) begin
            n_fail++;
            $display("FAIL b2b_merged: got %08h, expected 12345678", merged);
         end
      end
   endtask

   task automatic test_glitch();
      clear_mon();
      drive_bit(1'b0, 5);
      drive_bit(1'b1, 2 * CPB);
      n_checks += 2;
      if (q_data.size() !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d pulses, expected 0", q_data.size()); end
      if (n_ferr + n_perr !== 0) begin n_fail++; $display("FAIL glitch_err: got %0d pulses, expected 0", n_ferr + n_perr); end
      clear_mon();
      send_frame(8'h3C, 1'b1);
      drive_bit(1'b1, 2 * CPB);
      check_one_valid("glitch_next", 8'h3C);
   endtask

   task automatic test_frame_err();
      clear_mon();
      send_frame(8'h55, 1'b0);
      drive_bit(1'b0, 40 * CPB);
      drive_bit(1'b1, 2 * CPB);
      n_checks += 3;
      if (n_ferr !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d pulses, expected 1", n_ferr); end
      if (q_data.size() !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d pulses, expected 0", q_data.size()); end
      if (bus.data_o !== 8'sh3C) begin n_fail++; $display("FAIL ferr_hold: got %02h, expected 3c", bus.data_o); end
      clear_mon();
      send_frame(8'h0F, 1'b1);
      drive_bit(1'b1, 2 * CPB);
      check_one_valid("ferr_next", 8'h0F);
   endtask

   task automatic test_mid_reset();
      clear_mon();
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, CPB);
      drive_bit(1'b1, 5);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks += 2;
      if (bus.data_o !== 8'sd0) begin n_fail++; $display("FAIL midrst_data: got %02h, expected 00", bus.data_o); end
      if ({bus.valid_o, bus.frame_err_o, bus.parity_err_o} !== 3'b000) begin
         n_fail++;
         $display("FAIL midrst_flags: got %b, expected 000", {bus.valid_o, bus.frame_err_o, bus.parity_err_o});
      end
      drive_bit(1'b1, 6 * CPB);
      n_checks++;
      if (q_data.size() + n_ferr + n_perr !== 0) begin
         n_fail++;
         $display("FAIL midrst_pulses: got %0d pulses, expected 0", q_data.size() + n_ferr + n_perr);
      end
      clear_mon();
      send_frame(8'h81, 1'b1);
      drive_bit(1'b1, 2 * CPB);
      check_one_valid("midrst_next", 8'h81);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      clear_mon();
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 3; i++) drive_bit(1'b1, CPB);
      for (int i = 3; i < 8; i++) drive_bit(1'b0, CPB);
      drive_bit(1'b0, CPB);
      drive_bit(1'b1, 3 * CPB);
      n_checks += 2;
      if (n_perr !== 1) begin n_fail++; $display("FAIL parity_bad: got %0d pulses, expected 1", n_perr); end
      if (q_data.size() !== 0) begin n_fail++; $display("FAIL parity_bad_valid: got %0d pulses, expected 0", q_data.size()); end
      clear_mon();
      send_frame(8'h07, 1'b1);
      drive_bit(1'b1, 2 * CPB);
      check_one_valid("parity_good", 8'h07);
      n_checks++;
      if (q_vcyc.size() > 0 && (q_vcyc[0] - last_start) !== 171) begin
         n_fail++;
         $display("FAIL parity_latency: got %0d, expected 171", q_vcyc[0] - last_start);
      end
   endtask
`endif

   initial begin
      n_ferr  = 0;
      n_perr  = 0;
      n_multi = 0;
      last_start = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_mid_reset();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      n_checks++;
      if (n_multi !== 0) begin n_fail++; $display("FAIL onehot_flags: got %0d cycles with >1 flag, expected 0", n_multi); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001: Parameter CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (50 MHz / 115200 baud); legal values are even and at least 8.
- REQ-002: clk  input  1  system clock; every register updates on its rising edge.
- REQ-003: rst  input  1  reset; synchronous, active-high, sampled on the rising edge of clk.
- REQ-004: rx_i  input  1  asynchronous serial line; idle level is high.
- REQ-005: data_o  output  8 (signed)  last correctly received byte; drives data_uart_i of the downstream merge stage.
- REQ-006: valid_o  output  1  one-cycle pulse when data_o has just been updated; drives start_i of the merge stage.
- REQ-007: frame_err_o  output  1  one-cycle pulse when a stop bit is sampled low.
- REQ-008: parity_err_o  output  1  one-cycle pulse when the parity check fails (see Configuration).

Function
- REQ-009: rx_i shall pass through a two-flop synchronizer; all further logic uses only the synchronized value (rx_s).
- REQ-010: The FSM shall have the states IDLE, START, DATA, PARITY (only with the macro), STOP and WAIT_HIGH.
- REQ-011: IDLE: when rx_s is 0, go to START and clear the bit-timer.
- REQ-012: START: when the timer reaches CLKS_PER_BIT/2-1, sample rx_s. If 0, go to DATA. If 1, treat it as a glitch, go to IDLE, and raise no flag.
- REQ-013: DATA: sample rx_s each time the timer reaches CLKS_PER_BIT-1.
  - 8 bits, LSB first, shifted into an internal shift register.
  - A 3-bit index counter wraps from 7 to 0.
  - After bit 7, go to PARITY (macro defined) or STOP.
- REQ-014: STOP: sample at CLKS_PER_BIT-1. If 1 and there is no pending parity error, load data_o from the shift register, pulse valid_o, and go to IDLE.
- REQ-015: STOP sampled 0: pulse frame_err_o, leave data_o unchanged, do not pulse valid_o, and go to WAIT_HIGH.
- REQ-016: WAIT_HIGH: stay until rx_s is 1, then go to IDLE. A line held low (break) therefore yields exactly one frame_err_o pulse.
- REQ-017: Output timing:
  - valid_o, frame_err_o and parity_err_o are registered.
  - Each is high for exactly one cycle, the cycle after the stop-bit sample edge.
  - At most one of them is high in any cycle.
- REQ-018: Latency from rx_i falling to valid_o rising shall be 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, plus CLKS_PER_BIT with the macro defined.
- REQ-019: A new start bit shall be accepted from IDLE in the cycle directly after the stop sample, so back-to-back frames with no idle gap are received without loss.
- REQ-020: The bit-timer shall be sized to $clog2(CLKS_PER_BIT) bits and shall reset to 0 on every state change.

Reset
- REQ-021: While rst is high:
  - FSM goes to IDLE.
  - Timer, bit index and shift register are set to 0.
  - data_o is set to 0; valid_o, frame_err_o and parity_err_o are set to 0.
  - Both synchronizer flops are set to 1.
- REQ-022: A reset asserted mid-frame shall abort the frame with no flag pulsed. After rst falls, the remainder of that frame shall not produce valid_o unless a fresh falling edge is seen from IDLE.

Configuration
- REQ-023: The macro UART_RX_PARITY_EN shall select between two builds:
  - Defined: PARITY state is present; one even-parity bit is sampled after bit 7. A mismatch is latched, suppresses valid_o at STOP, and produces a parity_err_o pulse in place of valid_o. A frame error takes precedence over a parity error.
  - Undefined: no PARITY state; frames are 10 bits; parity_err_o is tied to 0; the port list is unchanged.

Verification (CLKS_PER_BIT=16)
- REQ-024: Reset, then send frame 0xA5 with a good stop bit -> one valid_o pulse with data_o=0xA5 (signed -91), 2+8+144+1=155 cycles after the falling edge; no error flags.
- REQ-025: Send 4 back-to-back frames 0x12,0x34,0x56,0x78 with no idle gap -> 4 valid_o pulses spaced 160 cycles apart, with data_o matching each byte. Feeding these into the merge stage yields 0x12345678.
- REQ-026: Drive a 5-cycle low glitch on idle rx_i -> no valid_o or error pulse; FSM returns to IDLE; a following 0x3C frame is received correctly.
- REQ-027: Send 0x55 with stop bit 0, then hold the line low for 40 bit times -> exactly one frame_err_o pulse; data_o keeps its previous value; the next good frame 0x0F gives valid_o.
- REQ-028: Assert rst for 1 cycle during bit 4 of frame 0xFF -> all outputs 0; no pulse for the aborted frame; the next frame 0x81 gives data_o=0x81.
- REQ-029: With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 (wrong) -> parity_err_o pulse, no valid_o. Send 0x07 with parity bit 1 -> valid_o pulse with 0x07 after 171 cycles.
